// File: rtl/writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage_if
// Purpose  : Groups the execute-side inputs, memory read data, forwarding
//            lookups and register-file write-port outputs of the writeback
//            stage into one bundle.
// Ports    : master - upstream/environment side (drives Ex*, MemRdData,
//                     FwdAddrA/B; observes Stall, Wb*, FwdHit*, RetireCount)
//            slave  - writeback_stage side (the reverse directions)
// Revision : 1.0 - initial release
// ============================================================================
interface writeback_stage_if #(
  parameter int W  = 8,
  parameter int A  = 3,
  parameter int CW = 16
);
  logic          ExValid;
  logic          ExIsLoad;
  logic          ExRegWrite;
  logic [1:0]    ExRegDest;
  logic [A-1:0]  ExWaddr;
  logic [W-1:0]  ExAluResult;
  logic [W-1:0]  MemRdData;
  logic [A-1:0]  FwdAddrA;
  logic [A-1:0]  FwdAddrB;
  logic          Stall;
  logic          WbRegWrite;
  logic [1:0]    WbRegDest;
  logic [A-1:0]  WbWaddr;
  logic [W-1:0]  WbData;
  logic          FwdHitA;
  logic          FwdHitB;
  logic [CW-1:0] RetireCount;

  modport master (
    output ExValid, ExIsLoad, ExRegWrite, ExRegDest, ExWaddr, ExAluResult,
           MemRdData, FwdAddrA, FwdAddrB,
    input  Stall, WbRegWrite, WbRegDest, WbWaddr, WbData, FwdHitA, FwdHitB,
           RetireCount
  );

  modport slave (
    input  ExValid, ExIsLoad, ExRegWrite, ExRegDest, ExWaddr, ExAluResult,
           MemRdData, FwdAddrA, FwdAddrB,
    output Stall, WbRegWrite, WbRegDest, WbWaddr, WbData, FwdHitA, FwdHitB,
           RetireCount
  );
endinterface
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : Final pipeline stage. Registers ALU results and load data, drives
//            the register-file write port, inserts the one-cycle load stall,
//            flags same-cycle write-through forwarding hits and counts
//            retired instructions.
// Ports    : Clk         - clock, all state updates on posedge
//            Reset       - asynchronous, active-high reset
//            bus (slave) - Ex* inputs, MemRdData, FwdAddrA/B in;
//                          Stall, Wb*, FwdHitA/B, RetireCount out
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
  parameter int W  = 8,
  parameter int A  = 3,
  parameter int CW = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  writeback_stage_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  // RegDest code that targets the register array; only these writes forward.
  localparam logic [1:0] c_DEST_ARRAY = 2'b00;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_wb_we;
  logic          w_wb_we_nxt;
  logic [1:0]    r_wb_dest;
  logic [1:0]    w_wb_dest_nxt;
  logic [A-1:0]  r_wb_waddr;
  logic [A-1:0]  w_wb_waddr_nxt;
  logic [W-1:0]  r_wb_data;
  logic [W-1:0]  w_wb_data_nxt;

  // Destination of a load waiting for its memory data.
  logic          r_pend_we;
  logic          w_pend_we_nxt;
  logic [1:0]    r_pend_dest;
  logic [1:0]    w_pend_dest_nxt;
  logic [A-1:0]  r_pend_waddr;
  logic [A-1:0]  w_pend_waddr_nxt;

  logic [CW-1:0] r_retire_cnt;
  logic          w_retire;

  // --------------------------------------------------------------------------
  // Next-state / next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_wb_we_nxt      = 1'b0;
    w_wb_dest_nxt    = r_wb_dest;
    w_wb_waddr_nxt   = r_wb_waddr;
    w_wb_data_nxt    = r_wb_data;
    w_pend_we_nxt    = r_pend_we;
    w_pend_dest_nxt  = r_pend_dest;
    w_pend_waddr_nxt = r_pend_waddr;
    w_retire         = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.ExValid) begin
          if (bus.ExIsLoad) begin
            // Park the destination; the data shows up next cycle.
            w_pend_we_nxt    = bus.ExRegWrite;
            w_pend_dest_nxt  = bus.ExRegDest;
            w_pend_waddr_nxt = bus.ExWaddr;
            w_state_nxt      = LOAD_WAIT;
          end else begin
            // Non-writing ops (stores, branches) still retire and still
            // update the address/data registers, with the write strobe low.
            w_wb_we_nxt    = bus.ExRegWrite;
            w_wb_dest_nxt  = bus.ExRegDest;
            w_wb_waddr_nxt = bus.ExWaddr;
            w_wb_data_nxt  = bus.ExAluResult;
            w_retire       = 1'b1;
          end
        end
      end
      LOAD_WAIT: begin
        // Ex* inputs are ignored here: upstream is holding them for the
        // next IDLE cycle.
        w_wb_we_nxt    = r_pend_we;
        w_wb_dest_nxt  = r_pend_dest;
        w_wb_waddr_nxt = r_pend_waddr;
        w_wb_data_nxt  = bus.MemRdData;
        w_retire       = 1'b1;
        w_state_nxt    = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_wb_we      <= 1'b0;
      r_wb_dest    <= 2'b00;
      r_wb_waddr   <= '0;
      r_wb_data    <= '0;
      r_pend_we    <= 1'b0;
      r_pend_dest  <= 2'b00;
      r_pend_waddr <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wb_we      <= w_wb_we_nxt;
      r_wb_dest    <= w_wb_dest_nxt;
      r_wb_waddr   <= w_wb_waddr_nxt;
      r_wb_data    <= w_wb_data_nxt;
      r_pend_we    <= w_pend_we_nxt;
      r_pend_dest  <= w_pend_dest_nxt;
      r_pend_waddr <= w_pend_waddr_nxt;
      if (w_retire) begin
        // Free-running; wraps to zero.
        r_retire_cnt <= r_retire_cnt + CW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.Stall       = (r_state == LOAD_WAIT);
  assign bus.WbRegWrite  = r_wb_we;
  assign bus.WbRegDest   = r_wb_dest;
  assign bus.WbWaddr     = r_wb_waddr;
  assign bus.WbData      = r_wb_data;
  assign bus.RetireCount = r_retire_cnt;

  // The register file commits at the end of this cycle, so a read issued now
  // would see stale contents; flag it so WbData is muxed in instead.
  assign bus.FwdHitA = r_wb_we && (r_wb_dest == c_DEST_ARRAY) &&
                       (r_wb_waddr == bus.FwdAddrA);
  assign bus.FwdHitB = r_wb_we && (r_wb_dest == c_DEST_ARRAY) &&
                       (r_wb_waddr == bus.FwdAddrB);

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. It registers ALU results and data-memory load results, then drives the write port of the 8-bit, 8-entry register file.
- It generates the one-cycle load stall.
- It provides same-cycle write-through forwarding for register-file reads. A register-file write lands only at the end of the cycle in which it is presented, so forwarding is needed for a read in that same cycle.
- It counts retired instructions.

Parameters:
W, 8, data path width (matches register file)
A, 3, register address width (2**A registers)
CW, 16, retired-instruction counter width

Ports:
Clk  in  1  clock, all state updates on posedge
Reset  in  1  asynchronous, active-high reset
ExValid  in  1  execute stage presents an instruction this cycle
ExIsLoad  in  1  instruction is a load; data arrives on MemRdData next cycle
ExRegWrite  in  1  instruction writes a destination
ExRegDest  in  2  destination select (2'b00 = register array; others = LFSR/special path)
ExWaddr  in  A  destination register
ExAluResult  in  W  result for non-load instructions
MemRdData  in  W  data memory read data, valid exactly one cycle after load issue
FwdAddrA  in  A  read address A being issued to register file this cycle
FwdAddrB  in  A  read address B being issued to register file this cycle
Stall  out  1  upstream must hold Ex* inputs and not advance
WbRegWrite  out  1  to register file RegWrite
WbRegDest  out  2  to register file RegDest
WbWaddr  out  A  to register file Waddr
WbData  out  W  to register file DataIn
FwdHitA  out  1  WbData must replace register-file output A
FwdHitB  out  1  WbData must replace register-file output B
RetireCount  out  CW  instructions retired since reset

Behaviour:
- States: IDLE, LOAD_WAIT. The state register, all Wb* outputs, and RetireCount are flops.
- Reset (async): state=IDLE; WbRegWrite=0; WbRegDest=2'b00; WbWaddr=0; WbData=0; RetireCount=0; Stall=0.
- Reset asserted during LOAD_WAIT abandons the pending load; no write occurs after release.
- Stall = (state==LOAD_WAIT). It is combinational from state only.
- IDLE, ExValid=1, ExIsLoad=0, at the edge:
  - WbRegWrite<=ExRegWrite; WbRegDest<=ExRegDest; WbWaddr<=ExWaddr; WbData<=ExAluResult.
  - RetireCount increments. State stays IDLE.
  - Latency: Ex cycle N -> Wb outputs valid in N+1 -> register file updated at end of N+1.
- IDLE, ExValid=1, ExIsLoad=1, at the edge:
  - Latch ExRegWrite/ExRegDest/ExWaddr into pending registers. WbRegWrite<=0. State<=LOAD_WAIT.
- LOAD_WAIT (exactly one cycle), at the edge:
  - WbRegWrite<=pending RegWrite; WbRegDest/WbWaddr<=pending values; WbData<=MemRdData.
  - RetireCount increments. State<=IDLE.
  - Load latency: issue N, stall N+1, Wb valid N+2.
- ExValid is ignored while Stall=1. Upstream re-presents the held instruction, and it is accepted on the first IDLE cycle.
- IDLE with ExValid=0: WbRegWrite<=0; other Wb outputs hold; no count.
- MemRdData is ignored in IDLE.
- ExRegWrite=0 (store, branch): the instruction retires (counter increments) with WbRegWrite=0; WbData/WbWaddr still update.
- Forwarding:
  - FwdHitA = WbRegWrite && WbRegDest==2'b00 && WbWaddr==FwdAddrA. FwdHitB is the same with FwdAddrB.
  - Combinational; no hit for a non-zero RegDest.
- Back-to-back loads: second load accepted on the cycle after LOAD_WAIT; that is one stall per load.
- RetireCount wraps from 2**CW-1 to 0 silently.

Test Plan:
- Reset mid-operation: assert Reset in LOAD_WAIT -> Stall=0, WbRegWrite=0, RetireCount=0 immediately. No write after release even if MemRdData=0x55.
- ALU writeback: ExValid=1, IsLoad=0, RegWrite=1, RegDest=00, Waddr=3, AluResult=0xA5 at cycle 0 -> cycle 1 WbRegWrite=1, WbWaddr=3, WbData=0xA5, RetireCount=1. FwdAddrA=3 -> FwdHitA=1; FwdAddrB=2 -> FwdHitB=0.
- Load: cycle 0 load Waddr=5; cycle 1 Stall=1, MemRdData=0x3C, WbRegWrite=0; cycle 2 WbRegWrite=1, WbWaddr=5, WbData=0x3C, Stall=0.
- Held instruction: during the stall cycle present ALU op Waddr=1 value 0x11 (held into cycle 2) -> accepted only in cycle 2, Wb in cycle 3. Retired exactly once; RetireCount=2.
- Non-array destination: RegDest=01, Waddr=4, FwdAddrA=4 -> WbRegWrite=1, WbRegDest=01, FwdHitA=0.
- Store-like op (RegWrite=0) -> WbRegWrite=0, RetireCount increments. Force counter to 0xFFFF, retire one -> RetireCount=0x0000.
